// File: rtl/ai_move_engine.sv
// GRIDxGRID tic-tac-toe opponent: captures a board on start, scans one cell per clock from a
// pseudo-random offset, then presents the chosen X move and updated board over valid/ready.
module ai_move_engine #(
  parameter int          GRID         = 3,
  parameter int          THINK_CYCLES = 4,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter int          IW           = $clog2(GRID*GRID+1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [2*GRID*GRID-1:0] board,
  input  logic [1:0]             level,
  output logic                   busy,
  output logic                   move_valid,
  input  logic                   move_ready,
  output logic [IW-1:0]          move,
  output logic [2*GRID*GRID-1:0] out_board,
  output logic                   no_move,
  output logic                   err_illegal,
  output logic [1:0]             dbg_state
);

  localparam int            CELLS   = GRID * GRID;
  localparam int            TW      = (THINK_CYCLES > 1) ? $clog2(THINK_CYCLES) : 1;
  localparam int            CTR     = (GRID / 2) * GRID + GRID / 2;
  localparam logic [IW-1:0] NONE    = IW'(CELLS);
  localparam logic [IW-1:0] LAST    = IW'(CELLS - 1);
  localparam logic [1:0]    C_EMPTY = 2'b00;
  localparam logic [1:0]    C_O     = 2'b01;
  localparam logic [1:0]    C_X     = 2'b10;
  localparam logic [1:0]    C_BAD   = 2'b11;

  typedef enum logic [1:0] {IDLE, SCAN, THINK, DONE} state_t;

  // Handshake: move_valid rises one edge after DONE is entered and then holds move, out_board,
  // no_move and err_illegal stable; the result is consumed on the first edge where
  // move_valid && move_ready, which also returns the block to IDLE.

  state_t               state, state_d;
  logic [15:0]          lfsr;
  logic [2*CELLS-1:0]   cap_board;
  logic [1:0]           cap_level;
  logic [IW-1:0]        cur, step;
  logic [TW-1:0]        tcnt;
  logic [IW-1:0]        rnd_pick, win_pick, blk_pick, col_pick, col_rank, lo_pick, cor_pick, cnt;
  logic [IW-1:0]        nx_rnd, nx_win, nx_blk, nx_col, nx_rank, nx_lo, nx_cor, nx_cnt;
  logic [IW-1:0]        sel;
  logic [2*CELLS-1:0]   mark_board;
  logic [1:0]           cells [CELLS];
  logic [IW-1:0]        rank_tab [CELLS];
  logic [CELLS-1:0]     corner_tab;
  logic [CELLS-1:0]     win_vec, blk_vec;
  logic [1:0]           cur_cell;
  logic                 cur_empty, last_step;

  // True when every other cell on some row, column or diagonal through cell c holds player p.
  function automatic logic owns_line(input logic [2*CELLS-1:0] b, input int c, input logic [1:0] p);
    int   r, q;
    logic rw, cl, dg, an;
    r  = c / GRID;
    q  = c % GRID;
    rw = 1'b1;
    cl = 1'b1;
    dg = (r == q);
    an = (r + q == GRID - 1);
    for (int j = 0; j < GRID; j++) begin
      if (j != q && b[2*(r*GRID+j) +: 2] != p)          rw = 1'b0;
      if (j != r && b[2*(j*GRID+q) +: 2] != p)          cl = 1'b0;
      if (j != r && b[2*(j*GRID+j) +: 2] != p)          dg = 1'b0;
      if (j != r && b[2*(j*GRID+GRID-1-j) +: 2] != p)   an = 1'b0;
    end
    return rw | cl | dg | an;
  endfunction

  always_comb begin
    win_vec    = '0;
    blk_vec    = '0;
    corner_tab = '0;
    for (int c = 0; c < CELLS; c++) begin
      cells[c]      = cap_board[2*c +: 2];
      rank_tab[c]   = IW'((c % GRID) * GRID + c / GRID);
      corner_tab[c] = (c == 0) || (c == GRID - 1) || (c == CELLS - GRID) || (c == CELLS - 1);
      win_vec[c]    = owns_line(cap_board, c, C_X);
      blk_vec[c]    = owns_line(cap_board, c, C_O);
    end
  end

  // Free-running Galois LFSR, x^16+x^14+x^13+x^11.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= LFSR_SEED;
    else        lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  assign last_step = (step == LAST);

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start) state_d = SCAN;
      SCAN:    if (last_step) state_d = (THINK_CYCLES == 0) ? DONE : THINK;
      THINK:   if (tcnt == TW'(THINK_CYCLES - 1)) state_d = DONE;
      DONE:    if (move_valid && move_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    dbg_state = state;
  end

  // Records updated with the cell visited this cycle.
  always_comb begin
    cur_cell  = cells[cur];
    cur_empty = (cur_cell == C_EMPTY);
    nx_rnd    = (rnd_pick == NONE && cur_empty) ? cur : rnd_pick;
    nx_win    = (win_pick == NONE && cur_empty && win_vec[cur]) ? cur : win_pick;
    nx_blk    = (blk_pick == NONE && cur_empty && blk_vec[cur]) ? cur : blk_pick;
    nx_lo     = (cur_empty && cur < lo_pick) ? cur : lo_pick;
    nx_cor    = (cur_empty && corner_tab[cur] && cur < cor_pick) ? cur : cor_pick;
    nx_col    = col_pick;
    nx_rank   = col_rank;
    if (cur_empty && rank_tab[cur] < col_rank) begin
      nx_col  = cur;
      nx_rank = rank_tab[cur];
    end
    nx_cnt    = cnt + IW'(cur_empty);
  end

  always_comb begin
    sel = nx_rnd;
    if (nx_cnt == '0) begin
      sel = NONE;
    end else if (nx_cnt == NONE && cap_level != 2'd0) begin
      sel = (GRID % 2 == 1) ? IW'(CTR) : '0;
    end else begin
      case (cap_level)
        2'd0: sel = nx_rnd;
        2'd1: sel = (nx_win != NONE) ? nx_win : (nx_blk != NONE) ? nx_blk : nx_rnd;
        2'd2: begin
          if (nx_win != NONE)                               sel = nx_win;
          else if (nx_blk != NONE)                          sel = nx_blk;
          else if (GRID % 2 == 1 && cells[CTR] == C_EMPTY)  sel = IW'(CTR);
          else if (nx_cor != NONE)                          sel = nx_cor;
          else                                              sel = nx_lo;
        end
        default: sel = nx_col;
      endcase
    end
  end

  always_comb begin
    mark_board = cap_board;
    for (int i = 0; i < CELLS; i++) begin
      if (sel == IW'(i)) mark_board[2*i+1] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_board   <= '0;
      cap_level   <= '0;
      cur         <= '0;
      step        <= '0;
      tcnt        <= '0;
      rnd_pick    <= NONE;
      win_pick    <= NONE;
      blk_pick    <= NONE;
      col_pick    <= NONE;
      col_rank    <= NONE;
      lo_pick     <= NONE;
      cor_pick    <= NONE;
      cnt         <= '0;
      move        <= '0;
      out_board   <= '0;
      no_move     <= 1'b0;
      err_illegal <= 1'b0;
      move_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cap_board   <= board;
            cap_level   <= level;
            cur         <= IW'(lfsr % 16'(CELLS));
            step        <= '0;
            rnd_pick    <= NONE;
            win_pick    <= NONE;
            blk_pick    <= NONE;
            col_pick    <= NONE;
            col_rank    <= NONE;
            lo_pick     <= NONE;
            cor_pick    <= NONE;
            cnt         <= '0;
            no_move     <= 1'b0;
            err_illegal <= 1'b0;
          end
        end
        SCAN: begin
          rnd_pick <= nx_rnd;
          win_pick <= nx_win;
          blk_pick <= nx_blk;
          col_pick <= nx_col;
          col_rank <= nx_rank;
          lo_pick  <= nx_lo;
          cor_pick <= nx_cor;
          cnt      <= nx_cnt;
          cur      <= (cur == LAST) ? '0 : cur + 1'b1;
          step     <= step + 1'b1;
          if (cur_cell == C_BAD) err_illegal <= 1'b1;
          if (last_step) begin
            move      <= sel;
            out_board <= mark_board;
            no_move   <= (nx_cnt == '0);
            tcnt      <= '0;
          end
        end
        THINK: tcnt <= tcnt + 1'b1;
        DONE: begin
          if (!move_valid)              move_valid <= 1'b1;
          else if (move_ready)          move_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
